// File: rtl/mips_pkg.sv
// Shared constants and encodings for the multi-cycle MIPS control unit:
// opcode/function values, FSM state codes and datapath select encodings.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   typedef enum logic [1:0] {REGDST_RT = 2'd0, REGDST_RD = 2'd1, REGDST_RA = 2'd2} reg_dst_e;
   typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_e;
   typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNC = 2'd2, ALU_IMM = 2'd3} alu_op_e;
   typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2} pc_sel_e;

   // I-type ALU instructions occupy the whole 0x08..0x0F block.
   function automatic logic isItypeAlu(input logic [5:0] op);
      return op[5:3] == 3'b001;
   endfunction

   function automatic logic isLoad(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LW);
   endfunction

   function automatic logic isStore(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SW);
   endfunction

   function automatic logic isBranch(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   function automatic logic isJump(input logic [5:0] op);
      return (op == OP_J) || (op == OP_JAL);
   endfunction

   function automatic logic isLegal(input logic [5:0] op);
      return (op == OP_RTYPE) || isJump(op) || isBranch(op) || isItypeAlu(op) ||
             isLoad(op) || isStore(op);
   endfunction

endpackage

// File: rtl/mips_wait_cnt.sv
// Loadable down-counter with a zero flag; it saturates at zero so a state
// can sit on "count done" without wrapping.
module mips_wait_cnt #(
   parameter int W       = 2,
   parameter int RST_VAL = 0
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         i_load,
   input  logic [W-1:0] i_loadVal,
   input  logic         i_dec,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_count <= W'(RST_VAL);
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for mips_core with
// parametrised memory wait states, illegal-opcode trap and retire counter.
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter int IMEM_WAIT = 1,
   parameter int DMEM_WAIT = 2,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic             alu_zero,
   output logic             ir_write,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wb_sel,
   output logic             alu_src,
   output logic [1:0]       alu_op,
   output logic             mem_read,
   output logic             mem_write_en,
   output logic             mem_byte,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   localparam int MAX_WAIT = (IMEM_WAIT > DMEM_WAIT) ? IMEM_WAIT : DMEM_WAIT;
   localparam int WCW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [2:0]       r_state;
   logic [2:0]       w_nextState;
   logic             r_halted;
   logic             r_illegal;
   logic [CNT_W-1:0] r_instret;

   logic             w_cntLoad;
   logic             w_cntDec;
   logic [WCW-1:0]   w_cntLoadVal;
   logic [WCW-1:0]   w_cnt;
   logic             w_cntZero;

   logic             w_retire;
   logic             w_isLoad;
   logic             w_isStore;
   logic             w_isSyscall;
   logic             w_isIllegal;
   logic             w_branchTaken;
   logic             w_memFirst;

   assign w_isLoad      = isLoad(opcode);
   assign w_isStore     = isStore(opcode);
   assign w_isSyscall   = (opcode == OP_RTYPE) && (func == FN_SYSCALL);
   assign w_isIllegal   = !isLegal(opcode);
   assign w_branchTaken = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
   // The counter is loaded with DMEM_WAIT on MEM entry, so it still holds that value only in the first MEM cycle.
   assign w_memFirst    = (w_cnt == WCW'(DMEM_WAIT));

   mips_wait_cnt #(
      .W      (WCW),
      .RST_VAL(IMEM_WAIT)
   ) u_waitCnt (
      .clk      (clk),
      .rst_b    (rst_b),
      .i_load   (w_cntLoad),
      .i_loadVal(w_cntLoadVal),
      .i_dec    (w_cntDec),
      .o_count  (w_cnt),
      .o_zero   (w_cntZero)
   );

   always_comb begin
      w_nextState  = r_state;
      w_retire     = 1'b0;
      w_cntLoad    = 1'b0;
      w_cntDec     = 1'b0;
      w_cntLoadVal = WCW'(IMEM_WAIT);
      case (r_state)
         S_FETCH: begin
            w_cntDec = 1'b1;
            if (w_cntZero) w_nextState = S_DECODE;
         end
         S_DECODE: begin
            w_nextState = (w_isSyscall || w_isIllegal) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            if (w_isLoad || w_isStore) begin
               w_nextState  = S_MEM;
               w_cntLoad    = 1'b1;
               w_cntLoadVal = WCW'(DMEM_WAIT);
            end else if (isBranch(opcode) || isJump(opcode)) begin
               w_nextState = S_FETCH;
               w_retire    = 1'b1;
            end else begin
               w_nextState = S_WB;
            end
         end
         S_MEM: begin
            w_cntDec = 1'b1;
            if (w_cntZero) begin
               if (w_isStore) begin
                  w_nextState = S_FETCH;
                  w_retire    = 1'b1;
               end else begin
                  w_nextState = S_WB;
               end
            end
         end
         S_WB: begin
            w_nextState = S_FETCH;
            w_retire    = 1'b1;
         end
         S_HALT:  w_nextState = S_HALT;
         default: w_nextState = S_FETCH;
      endcase
      if (w_retire) begin
         w_cntLoad    = 1'b1;
         w_cntLoadVal = WCW'(IMEM_WAIT);
      end
   end

   // Outputs are forced low while reset is held so IMEM_WAIT=0 cannot raise ir_write during reset.
   always_comb begin
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = REGDST_RT;
      wb_sel       = WB_ALU;
      alu_src      = 1'b0;
      alu_op       = ALU_ADD;
      mem_read     = 1'b0;
      mem_write_en = 1'b0;
      mem_byte     = 1'b0;
      pc_write     = 1'b0;
      pc_sel       = PC_PLUS4;
      if (rst_b) begin
         case (r_state)
            S_FETCH: ir_write = w_cntZero;
            S_EXEC: begin
               if (w_isLoad || w_isStore) begin
                  alu_op  = ALU_ADD;
                  alu_src = 1'b1;
               end else if (isBranch(opcode)) begin
                  alu_op   = ALU_SUB;
                  pc_write = 1'b1;
                  pc_sel   = w_branchTaken ? PC_BRANCH : PC_PLUS4;
               end else if (isJump(opcode)) begin
                  pc_write = 1'b1;
                  pc_sel   = PC_JUMP;
                  if (opcode == OP_JAL) begin
                     reg_write = 1'b1;
                     reg_dst   = REGDST_RA;
                     wb_sel    = WB_PC4;
                  end
               end else if (isItypeAlu(opcode)) begin
                  alu_op  = ALU_IMM;
                  alu_src = 1'b1;
               end else begin
                  alu_op  = ALU_FUNC;
                  alu_src = 1'b0;
               end
            end
            S_MEM: begin
               mem_byte = (opcode == OP_LB) || (opcode == OP_SB);
               if (w_isLoad) begin
                  mem_read = 1'b1;
               end else begin
                  mem_write_en = w_memFirst;
                  if (w_cntZero) begin
                     pc_write = 1'b1;
                     pc_sel   = PC_PLUS4;
                  end
               end
            end
            S_WB: begin
               reg_write = 1'b1;
               pc_write  = 1'b1;
               pc_sel    = PC_PLUS4;
               reg_dst   = (opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
               wb_sel    = w_isLoad ? WB_MEM : WB_ALU;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state   <= S_FETCH;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
         r_instret <= '0;
      end else begin
         r_state <= w_nextState;
         if ((r_state == S_DECODE) && (w_isSyscall || w_isIllegal)) begin
            r_halted  <= 1'b1;
            r_illegal <= w_isIllegal;
         end
         if (w_retire) r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign halted  = r_halted;
   assign illegal = r_illegal;
   assign instret = r_instret;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: three parameterisations, each checked cycle by cycle
// against a per-instruction schedule derived from the instruction class.
module tb_mips_mc_ctrl;

   localparam int X = -1;
   localparam logic [14:0] STROBES = 15'h6034;

   typedef struct packed {
      logic [14:0] val;
      logic [14:0] mask;
      logic        h;
      logic        il;
   } step_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstA, rstB, rstC;
   logic [5:0] opcode, func;
   logic       aluZero;

   wire [14:0] ctlA, ctlB, ctlC;
   wire        hA, hB, hC, ilA, ilB, ilC;
   wire [31:0] retA, retC;
   wire [3:0]  retB;

   mips_mc_ctrl #(.IMEM_WAIT(1), .DMEM_WAIT(2), .CNT_W(32)) dutA (
      .clk(clk), .rst_b(rstA), .opcode(opcode), .func(func), .alu_zero(aluZero),
      .ir_write(ctlA[14]), .reg_write(ctlA[13]), .reg_dst(ctlA[12:11]), .wb_sel(ctlA[10:9]),
      .alu_src(ctlA[8]), .alu_op(ctlA[7:6]), .mem_read(ctlA[5]), .mem_write_en(ctlA[4]),
      .mem_byte(ctlA[3]), .pc_write(ctlA[2]), .pc_sel(ctlA[1:0]),
      .halted(hA), .illegal(ilA), .instret(retA));

   mips_mc_ctrl #(.IMEM_WAIT(1), .DMEM_WAIT(2), .CNT_W(4)) dutB (
      .clk(clk), .rst_b(rstB), .opcode(opcode), .func(func), .alu_zero(aluZero),
      .ir_write(ctlB[14]), .reg_write(ctlB[13]), .reg_dst(ctlB[12:11]), .wb_sel(ctlB[10:9]),
      .alu_src(ctlB[8]), .alu_op(ctlB[7:6]), .mem_read(ctlB[5]), .mem_write_en(ctlB[4]),
      .mem_byte(ctlB[3]), .pc_write(ctlB[2]), .pc_sel(ctlB[1:0]),
      .halted(hB), .illegal(ilB), .instret(retB));

   mips_mc_ctrl #(.IMEM_WAIT(0), .DMEM_WAIT(0), .CNT_W(32)) dutC (
      .clk(clk), .rst_b(rstC), .opcode(opcode), .func(func), .alu_zero(aluZero),
      .ir_write(ctlC[14]), .reg_write(ctlC[13]), .reg_dst(ctlC[12:11]), .wb_sel(ctlC[10:9]),
      .alu_src(ctlC[8]), .alu_op(ctlC[7:6]), .mem_read(ctlC[5]), .mem_write_en(ctlC[4]),
      .mem_byte(ctlC[3]), .pc_write(ctlC[2]), .pc_sel(ctlC[1:0]),
      .halted(hC), .illegal(ilC), .instret(retC));

   int          cur;
   int          imw[3]    = '{1, 1, 0};
   int          dmw[3]    = '{2, 2, 0};
   int          cntWid[3] = '{32, 4, 32};
   longint      expRet;
   step_t       expQ[$];
   int          errors = 0;
   int          checks = 0;
   int          legalOps[17] = '{0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 32, 35, 40, 43};

   logic [14:0] obsCtl;
   logic        obsH, obsIl;
   logic [31:0] obsRet;

   always_comb begin
      case (cur)
         0:       begin obsCtl = ctlA; obsH = hA; obsIl = ilA; obsRet = retA; end
         1:       begin obsCtl = ctlB; obsH = hB; obsIl = ilB; obsRet = {28'd0, retB}; end
         default: begin obsCtl = ctlC; obsH = hC; obsIl = ilC; obsRet = retC; end
      endcase
   end

   // Fields in output order; a negative argument means "not constrained in this cycle".
   function automatic step_t mkStep(input int irw, rw, rd, wb, asr, ao, mr, mw, mb, pw, ps,
                                    input logic h, il);
      int    f[11];
      int    fw[11];
      step_t s;
      f  = '{irw, rw, rd, wb, asr, ao, mr, mw, mb, pw, ps};
      fw = '{1, 1, 2, 2, 1, 2, 1, 1, 1, 1, 2};
      s  = '0;
      s.h  = h;
      s.il = il;
      for (int i = 0; i < 11; i++) begin
         s.val  = s.val << fw[i];
         s.mask = s.mask << fw[i];
         if (f[i] >= 0) begin
            s.val  = s.val | 15'(f[i]);
            s.mask = s.mask | 15'((1 << fw[i]) - 1);
         end
      end
      return s;
   endfunction

   // Expected per-cycle behaviour of one instruction; returns 1 if it retires.
   function automatic bit buildSchedule(input int op, fn, zr, imWait, dmWait);
      bit isLd, isSt, byteAcc, legal, taken;
      expQ.delete();
      for (int i = 0; i < imWait; i++) expQ.push_back(mkStep(0, 0, X, X, X, X, 0, 0, X, 0, X, 0, 0));
      expQ.push_back(mkStep(1, 0, X, X, X, X, 0, 0, X, 0, X, 0, 0));
      expQ.push_back(mkStep(0, 0, X, X, X, X, 0, 0, X, 0, X, 0, 0));
      legal   = (op == 0) || (op >= 2 && op <= 5) || (op >= 8 && op <= 15) ||
                op == 32 || op == 35 || op == 40 || op == 43;
      isLd    = (op == 32) || (op == 35);
      isSt    = (op == 40) || (op == 43);
      byteAcc = (op == 32) || (op == 40);
      if (!legal || (op == 0 && fn == 12)) begin
         for (int i = 0; i < 20; i++)
            expQ.push_back(mkStep(0, 0, X, X, X, X, 0, 0, X, 0, X, 1'b1, !legal));
         return 1'b0;
      end
      if (op == 0) begin
         expQ.push_back(mkStep(0, 0, X, X, 0, 2, 0, 0, X, 0, X, 0, 0));
         expQ.push_back(mkStep(0, 1, 1, 0, X, X, 0, 0, X, 1, 0, 0, 0));
      end else if (op >= 8 && op <= 15) begin
         expQ.push_back(mkStep(0, 0, X, X, 1, 3, 0, 0, X, 0, X, 0, 0));
         expQ.push_back(mkStep(0, 1, 0, 0, X, X, 0, 0, X, 1, 0, 0, 0));
      end else if (isLd || isSt) begin
         expQ.push_back(mkStep(0, 0, X, X, 1, 0, 0, 0, X, 0, X, 0, 0));
         for (int k = 0; k <= dmWait; k++) begin
            if (isLd) expQ.push_back(mkStep(0, 0, X, X, X, X, 1, 0, int'(byteAcc), 0, X, 0, 0));
            else      expQ.push_back(mkStep(0, 0, X, X, X, X, 0, int'(k == 0), int'(byteAcc),
                                            int'(k == dmWait), (k == dmWait) ? 0 : X, 0, 0));
         end
         if (isLd) expQ.push_back(mkStep(0, 1, 0, 1, X, X, 0, 0, X, 1, 0, 0, 0));
      end else if (op == 4 || op == 5) begin
         taken = (op == 4) ? (zr != 0) : (zr == 0);
         expQ.push_back(mkStep(0, 0, X, X, X, 1, 0, 0, X, 1, taken ? 1 : 0, 0, 0));
      end else if (op == 2) begin
         expQ.push_back(mkStep(0, 0, X, X, X, X, 0, 0, X, 1, 2, 0, 0));
      end else begin
         expQ.push_back(mkStep(0, 1, 2, 2, X, X, 0, 0, X, 1, 2, 0, 0));
      end
      return 1'b1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered just after a falling edge; runs the instruction for maxCycles (or all, if negative).
   task automatic applyStimulus(input int op, fn, zr, maxCycles);
      bit    ret;
      int    n;
      step_t s;
      ret     = buildSchedule(op, fn, zr, imw[cur], dmw[cur]);
      opcode  = 6'(op);
      func    = 6'(fn);
      aluZero = zr[0];
      n       = expQ.size();
      if (maxCycles >= 0 && maxCycles < n) begin
         n   = maxCycles;
         ret = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         #1;
         s = expQ[i];
         checkOutput($sformatf("ctl dut%0d op=%0h cyc=%0d", cur, op, i + 1), {17'd0, obsCtl & s.mask}, {17'd0, s.val});
         checkOutput($sformatf("halted dut%0d op=%0h cyc=%0d", cur, op, i + 1), {31'd0, obsH}, {31'd0, s.h});
         checkOutput($sformatf("illegal dut%0d op=%0h cyc=%0d", cur, op, i + 1), {31'd0, obsIl}, {31'd0, s.il});
         checkOutput($sformatf("instret dut%0d op=%0h cyc=%0d", cur, op, i + 1), obsRet, 32'(expRet));
         @(negedge clk);
      end
      if (ret) expRet = (expRet + 1) & ((64'd1 << cntWid[cur]) - 1);
   endtask

   task automatic resetDut(input int d);
      cur = d;
      case (d)
         0:       rstA = 1'b0;
         1:       rstB = 1'b0;
         default: rstC = 1'b0;
      endcase
      #1;
      checkOutput($sformatf("resetStrobes dut%0d", d), {17'd0, obsCtl & STROBES}, 32'd0);
      checkOutput($sformatf("resetHalted dut%0d", d), {31'd0, obsH}, 32'd0);
      checkOutput($sformatf("resetIllegal dut%0d", d), {31'd0, obsIl}, 32'd0);
      checkOutput($sformatf("resetInstret dut%0d", d), obsRet, 32'd0);
      @(negedge clk);
      case (d)
         0:       rstA = 1'b1;
         1:       rstB = 1'b1;
         default: rstC = 1'b1;
      endcase
      expRet = 0;
   endtask

   task automatic randomInstr(input int count);
      int op, fn, zr;
      for (int i = 0; i < count; i++) begin
         op = legalOps[$urandom_range(0, 16)];
         fn = int'($urandom_range(0, 63));
         if (op == 0 && fn == 12) fn = 32;
         zr = int'($urandom_range(0, 1));
         applyStimulus(op, fn, zr, -1);
      end
   endtask

   initial begin
      cur     = 0;
      expRet  = 0;
      rstA    = 1'b0;
      rstB    = 1'b0;
      rstC    = 1'b0;
      opcode  = 6'd0;
      func    = 6'd0;
      aluZero = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] dutA: IMEM_WAIT=1 DMEM_WAIT=2");
      resetDut(0);
      applyStimulus(6'h23, 0, 0, 5);
      resetDut(0);
      applyStimulus(6'h00, 6'h20, 0, -1);
      applyStimulus(6'h23, 0, 0, -1);
      applyStimulus(6'h2B, 0, 0, -1);
      applyStimulus(6'h04, 0, 1, -1);
      applyStimulus(6'h05, 0, 1, -1);
      applyStimulus(6'h04, 0, 0, -1);
      applyStimulus(6'h02, 0, 0, -1);
      applyStimulus(6'h03, 0, 0, -1);
      applyStimulus(6'h20, 0, 0, -1);
      applyStimulus(6'h28, 0, 0, -1);
      applyStimulus(6'h08, 0, 0, -1);
      randomInstr(30);
      applyStimulus(6'h3F, 0, 0, -1);
      resetDut(0);
      applyStimulus(6'h00, 6'h0C, 0, -1);

      $display("[TB] dutB: CNT_W=4 wrap");
      resetDut(1);
      for (int i = 0; i < 17; i++) applyStimulus(6'h00, 6'h20, 0, -1);
      #1;
      checkOutput("instretWrap", obsRet, 32'd1);
      @(negedge clk);
      resetDut(1);

      $display("[TB] dutC: IMEM_WAIT=0 DMEM_WAIT=0");
      resetDut(2);
      applyStimulus(6'h23, 0, 0, -1);
      applyStimulus(6'h2B, 0, 0, -1);
      applyStimulus(6'h00, 6'h22, 0, -1);
      randomInstr(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
